rf_mp: RTL

//   Parametrised multi-port register file for the matrix divider datapath.

---
 rtl/rf_mp.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_mp.sv
// ---------------------------------------------------------------------------
// rf_mp: parametrised multi-port register file for the matrix divider datapath
//
// Holds DEPTH entries of WIDTH bits. It has NRD combinational read ports and
// two prioritised write ports; port 0 wins when both ports hit one address.
// Each entry carries a valid bit. An optional write-to-read bypass is
// available. A sequential clear engine wipes one entry per cycle so the
// controller can scrub operands between matrix jobs.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   we0_i       write enable, port 0 (highest priority)
//   wa0_i       write address, port 0
//   wd0_i       write data, port 0
//   we1_i       write enable, port 1
//   wa1_i       write address, port 1
//   wd1_i       write data, port 1
//   ra_i        read addresses, port i = ra_i[i*AW +: AW]
//   rd_o        read data, port i = rd_o[i*WIDTH +: WIDTH]
//   rvalid_o    per read port: entry written since last reset/clear
//   clr_i       start a clear sweep (sampled only when idle)
//   busy_o      clear sweep in progress
//   clr_done_o  one-cycle pulse after the sweep completes
//   wr_drop_o   one-cycle pulse: a write was discarded
// ---------------------------------------------------------------------------
module rf_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int NRD    = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we0_i,
    input  logic [AW-1:0]        wa0_i,
    input  logic [WIDTH-1:0]     wd0_i,
    input  logic                 we1_i,
    input  logic [AW-1:0]        wa1_i,
    input  logic [WIDTH-1:0]     wd1_i,
    input  logic [NRD*AW-1:0]    ra_i,
    output logic [NRD*WIDTH-1:0] rd_o,
    output logic [NRD-1:0]       rvalid_o,
    input  logic                 clr_i,
    output logic                 busy_o,
    output logic                 clr_done_o,
    output logic                 wr_drop_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic                 clr_done_q, clr_done_d;
    logic                 wr_drop_q, wr_drop_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;

    logic                 acc0_s;
    logic                 acc1_s;
    logic                 sweep_s;
    logic [NRD*WIDTH-1:0] rd_s;
    logic [NRD-1:0]       rvalid_s;

    // An address is backed by storage only below DEPTH.
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_C);
    endfunction

    // Write acceptance: only when idle and out of reset. Port 1 loses to
    // port 0 on an address collision. Gating with rst_n keeps the bypass
    // path from showing data while the file is held in reset.
    always_comb begin
        acc0_s = 1'b0;
        acc1_s = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            acc0_s = we0_i && in_range(wa0_i);
            acc1_s = we1_i && in_range(wa1_i) && !(acc0_s && (wa0_i == wa1_i));
        end else begin
            acc0_s = 1'b0;
            acc1_s = 1'b0;
        end
    end

    // Clear-engine next state and the pulse outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        sweep_s    = 1'b0;
        // Any requested write that was not accepted counts as a drop.
        wr_drop_d  = (we0_i && !acc0_s) || (we1_i && !acc1_s);
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                sweep_s = 1'b1;
                if (ptr_q == LAST_C) begin
                    state_d    = ST_IDLE;
                    ptr_d      = {AW{1'b0}};
                    clr_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = {AW{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= {AW{1'b0}};
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_done_q <= clr_done_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // Storage array: the sweep clears one entry per cycle, and accepted
    // writes update the other entries. Writes are never accepted while
    // sweeping, so the two sources never meet on one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {WIDTH{1'b0}};
            end
            valid_q <= {DEPTH{1'b0}};
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (sweep_s && (ptr_q == AW'(k))) begin
                    mem_q[k]   <= {WIDTH{1'b0}};
                    valid_q[k] <= 1'b0;
                end else if (acc0_s && (wa0_i == AW'(k))) begin
                    mem_q[k]   <= wd0_i;
                    valid_q[k] <= 1'b1;
                end else if (acc1_s && (wa1_i == AW'(k))) begin
                    mem_q[k]   <= wd1_i;
                    valid_q[k] <= 1'b1;
                end
            end
        end
    end

    // Combinational read ports. The bypass is applied in increasing
    // priority order, so port 0 overrides port 1 on a shared address.
    always_comb begin
        logic [AW-1:0] addr;
        rd_s     = {(NRD*WIDTH){1'b0}};
        rvalid_s = {NRD{1'b0}};
        addr     = {AW{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            addr = ra_i[i*AW +: AW];
            if (in_range(addr)) begin
                rd_s[i*WIDTH +: WIDTH] = mem_q[addr];
                rvalid_s[i]            = valid_q[addr];
            end else begin
                rd_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                rvalid_s[i]            = 1'b0;
            end
            if (BYPASS && acc1_s && (wa1_i == addr)) begin
                rd_s[i*WIDTH +: WIDTH] = wd1_i;
                rvalid_s[i]            = 1'b1;
            end else begin
                rvalid_s[i] = rvalid_s[i];
            end
            if (BYPASS && acc0_s && (wa0_i == addr)) begin
                rd_s[i*WIDTH +: WIDTH] = wd0_i;
                rvalid_s[i]            = 1'b1;
            end else begin
                rvalid_s[i] = rvalid_s[i];
            end
        end
    end

    assign rd_o       = rd_s;
    assign rvalid_o   = rvalid_s;
    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_done_o = clr_done_q;
    assign wr_drop_o  = wr_drop_q;

endmodule
